cpu_sequencer: RTL

Multi-cycle control unit for the 8-bit CPU. It fetches 16-bit instructions over a request/acknowledge instruction-memory port, holds them in the instruction register, and steps the datapath through decode, execute, memory and writeback. It drives ALU, register-file and data-memory controls and owns the program counter. It sits inside `cpu`, between the memories and the ALU/register-file datapath.

---
 rtl/cpu_pkg.sv | 57 +++++
 rtl/cpu_sequencer_if.sv | 47 ++++
 rtl/cpu_seq_decode.sv | 38 +++
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
//  cpu_pkg
//  Shared opcodes, ALU encodings, sequencer states and the decoded control
//  word used by the cpu_sequencer slice.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_XOR    = 3'b100;
  localparam logic [2:0] ALU_PASS_B = 3'b101;

  // ST_PAUSE is only reachable when single-stepping is compiled in.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_PAUSE  = 3'd6
  } state_t;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       src_imm;
    logic       reg_we;
    logic       wsel_mem;
    logic       is_mem;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_halt;
    logic       illegal;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/cpu_sequencer_if.sv
// ============================================================================
//  cpu_sequencer_if
//  Memory, ALU and register-file control bundle between the sequencer
//  (master) and the memories/datapath (slave).
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface cpu_sequencer_if #(
  parameter int PC_WIDTH = 8
);
  logic                IMEM_REQ;
  logic [PC_WIDTH-1:0] IMEM_ADDR;
  logic                IMEM_ACK;
  logic [15:0]         IMEM_RDATA;
  logic                DMEM_REQ;
  logic                DMEM_WE;
  logic [7:0]          DMEM_ADDR;
  logic                DMEM_ACK;
  logic [2:0]          ALU_OP;
  logic                ALU_SRC_IMM;
  logic                ALU_ZERO;
  logic                REG_WE;
  logic                REG_WSEL_MEM;
  logic [15:0]         Instruction;
  logic [PC_WIDTH-1:0] PC;
  logic                HALTED;
  logic                FAULT;
  logic                ILLEGAL;

  modport master (
    output IMEM_REQ, IMEM_ADDR, DMEM_REQ, DMEM_WE, DMEM_ADDR,
           ALU_OP, ALU_SRC_IMM, REG_WE, REG_WSEL_MEM,
           Instruction, PC, HALTED, FAULT, ILLEGAL,
    input  IMEM_ACK, IMEM_RDATA, DMEM_ACK, ALU_ZERO
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, DMEM_REQ, DMEM_WE, DMEM_ADDR,
           ALU_OP, ALU_SRC_IMM, REG_WE, REG_WSEL_MEM,
           Instruction, PC, HALTED, FAULT, ILLEGAL,
    output IMEM_ACK, IMEM_RDATA, DMEM_ACK, ALU_ZERO
  );

endinterface

`default_nettype wire

// File: rtl/cpu_seq_decode.sv
// ============================================================================
//  cpu_seq_decode
//  Purely combinational opcode to control-word decoder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_seq_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    case (opcode)
      OP_NOP:  ;
      OP_ADD:  ctrl.reg_we = 1'b1;
      OP_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.reg_we = 1'b1; end
      OP_AND:  begin ctrl.alu_op = ALU_AND; ctrl.reg_we = 1'b1; end
      OP_OR:   begin ctrl.alu_op = ALU_OR;  ctrl.reg_we = 1'b1; end
      OP_XOR:  begin ctrl.alu_op = ALU_XOR; ctrl.reg_we = 1'b1; end
      OP_ADDI: begin ctrl.src_imm = 1'b1; ctrl.reg_we = 1'b1; end
      OP_LD:   begin ctrl.is_mem = 1'b1; ctrl.reg_we = 1'b1; ctrl.wsel_mem = 1'b1; end
      OP_ST:   begin ctrl.is_mem = 1'b1; ctrl.is_store = 1'b1; end
      OP_BEQ:  begin ctrl.alu_op = ALU_SUB; ctrl.is_branch = 1'b1; end
      OP_JMP:  ctrl.is_jump = 1'b1;
      OP_HLT:  ctrl.is_halt = 1'b1;
      // Undefined opcodes behave as NOP apart from the ILLEGAL flag.
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ============================================================================
//  cpu_sequencer
//  Multi-cycle fetch/decode/exec/mem/writeback control unit with PC,
//  instruction register and acknowledge timeout.
//  Optional feature macro: CPU_SEQ_STEP_EN (adds STEP input and PAUSE state).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH   = 8,
  parameter int RESET_PC   = 0,
  parameter int WAIT_LIMIT = 15
) (
  input  logic CLK,
  input  logic RESET_N,
`ifdef CPU_SEQ_STEP_EN
  input  logic STEP,
`endif
  cpu_sequencer_if.master bus
);

  localparam int                  CNT_W    = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [CNT_W-1:0]    LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);
  localparam logic [PC_WIDTH-1:0] RST_PC   = PC_WIDTH'(RESET_PC);

  state_t              r_state;
  state_t              w_next;
  logic                r_started;
  logic                r_taken;
  logic                r_fault;
  logic [15:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]    r_wait;
  ctrl_t               w_ctrl;
  logic                w_wait_req;
  logic                w_wait_ack;
  logic                w_timeout;

  cpu_seq_decode u_decode (
    .opcode (r_instr[15:12]),
    .ctrl   (w_ctrl)
  );

  // r_started keeps FETCH silent for the cycle in which reset is released.
  always_comb begin
    w_wait_req = ((r_state == ST_FETCH) && r_started) || (r_state == ST_MEM);
    w_wait_ack = (r_state == ST_FETCH) ? bus.IMEM_ACK : bus.DMEM_ACK;
    w_timeout  = w_wait_req && !w_wait_ack && (r_wait == LIMIT_M1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (r_started) begin
          if (bus.IMEM_ACK)  w_next = ST_DECODE;
          else if (w_timeout) w_next = ST_HALT;
        end
      end
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        if (w_ctrl.is_halt)     w_next = ST_HALT;
        else if (w_ctrl.is_mem) w_next = ST_MEM;
        else                    w_next = ST_WB;
      end
      ST_MEM: begin
        if (bus.DMEM_ACK)   w_next = ST_WB;
        else if (w_timeout) w_next = ST_HALT;
      end
`ifdef CPU_SEQ_STEP_EN
      ST_WB:    w_next = ST_PAUSE;
      ST_PAUSE: if (STEP) w_next = ST_FETCH;
`else
      ST_WB:    w_next = ST_FETCH;
`endif
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= ST_FETCH;
      r_started <= 1'b0;
      r_taken   <= 1'b0;
      r_fault   <= 1'b0;
      r_instr   <= '0;
      r_pc      <= RST_PC;
      r_wait    <= '0;
    end else begin
      r_state   <= w_next;
      r_started <= 1'b1;
      r_fault   <= r_fault | w_timeout;
      if ((r_state == ST_FETCH) && r_started && bus.IMEM_ACK)
        r_instr <= bus.IMEM_RDATA;
      if (r_state == ST_EXEC)
        r_taken <= w_ctrl.is_branch & bus.ALU_ZERO;
      if (r_state == ST_WB) begin
        if (w_ctrl.is_jump || (w_ctrl.is_branch && r_taken))
          r_pc <= PC_WIDTH'(r_instr[7:0]);
        else
          r_pc <= r_pc + PC_WIDTH'(1);
      end
      // Any state change restarts the acknowledge wait count.
      if (w_next != r_state)
        r_wait <= '0;
      else if (w_wait_req && !w_wait_ack)
        r_wait <= r_wait + CNT_W'(1);
    end
  end

  assign bus.IMEM_REQ     = (r_state == ST_FETCH) && r_started;
  assign bus.IMEM_ADDR    = r_pc;
  assign bus.DMEM_REQ     = (r_state == ST_MEM);
  assign bus.DMEM_WE      = (r_state == ST_MEM) && w_ctrl.is_store;
  assign bus.DMEM_ADDR    = r_instr[7:0];
  assign bus.ALU_OP       = (r_state == ST_EXEC) ? w_ctrl.alu_op : ALU_ADD;
  assign bus.ALU_SRC_IMM  = (r_state == ST_EXEC) && w_ctrl.src_imm;
  assign bus.REG_WE       = (r_state == ST_WB) && w_ctrl.reg_we;
  assign bus.REG_WSEL_MEM = (r_state == ST_WB) && w_ctrl.wsel_mem;
  assign bus.Instruction  = r_instr;
  assign bus.PC           = r_pc;
  assign bus.HALTED       = (r_state == ST_HALT);
  assign bus.FAULT        = r_fault;
  assign bus.ILLEGAL      = (r_state == ST_DECODE) && w_ctrl.illegal;

endmodule

`default_nettype wire
